// File: rtl/gpr_wr_arb_pkg.sv
// Shared types and defaults for the GPR write-port arbiter.
// Optional feature macro: GPR_WR_ARB_STARVE_EN.
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef DATA_ZERO
`define DATA_ZERO {`DATA_WIDTH{1'b0}}
`endif

package gpr_wr_arb_pkg;

    typedef struct packed {
        logic [`GPRS_WIDTH-1:0] id;
        logic [`DATA_WIDTH-1:0] data;
    } gpr_wr_ent_t;

    localparam int GPR_WR_DEPTH      = 4;
    localparam int GPR_WR_STARVE_MAX = 8;

endpackage

// File: rtl/gpr_wr_arb_if.sv
// MDU result handshake into the GPR write arbiter.
// master: MDU (valid/id/data out, ready in); slave: arbiter.
interface gpr_wr_arb_if;

    logic                   i_mdu_valid;
    logic                   o_arb_mdu_ready;
    logic [`GPRS_WIDTH-1:0] i_mdu_gpr_wr_id;
    logic [`DATA_WIDTH-1:0] i_mdu_gpr_wr_data;

    modport master (
        output i_mdu_valid,
        output i_mdu_gpr_wr_id,
        output i_mdu_gpr_wr_data,
        input  o_arb_mdu_ready
    );

    modport slave (
        input  i_mdu_valid,
        input  i_mdu_gpr_wr_id,
        input  i_mdu_gpr_wr_data,
        output o_arb_mdu_ready
    );

endinterface

// File: rtl/gpr_wr_fifo.sv
// Circular buffer of queued MDU results.
// Ports: clk/rst_n, push+entry, pop, head, full/empty, per-slot valid/id.
module gpr_wr_fifo
    import gpr_wr_arb_pkg::*;
#(
    parameter int DEPTH = GPR_WR_DEPTH
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_push,
    input  gpr_wr_ent_t                        i_push_ent,
    input  logic                               i_pop,
    output gpr_wr_ent_t                        o_head,
    output logic                               o_full,
    output logic                               o_empty,
    output logic [DEPTH-1:0]                   o_vld,
    output logic [DEPTH-1:0][`GPRS_WIDTH-1:0]  o_ids
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    gpr_wr_ent_t r_mem [DEPTH];
    logic [AW:0] w_cnt;

    assign w_cnt   = r_wptr - r_rptr;
    assign o_empty = (r_wptr == r_rptr);
    // Same slot index, opposite lap bit: writer is one lap ahead.
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_head  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_push_ent;
    end

    // A slot is occupied when its distance from the read slot
    // is below the occupancy count.
    always_comb begin
        logic [AW-1:0] v_off;
        for (int i = 0; i < DEPTH; i++) begin
            v_off    = AW'(i) - r_rptr[AW-1:0];
            o_vld[i] = ({1'b0, v_off} < w_cnt);
            o_ids[i] = r_mem[i].id;
        end
    end

endmodule

// File: rtl/gpr_wr_arb.sv
// GPR write-port arbiter: pipeline passes through, MDU results queue.
// Ports: clk/rst_n, wbu req/ready, mdu if, rs1/rs2 pend, gpr write.
// Macro GPR_WR_ARB_STARVE_EN enables the forced-drain starve guard.
module gpr_wr_arb
    import gpr_wr_arb_pkg::*;
#(
    parameter int DEPTH      = GPR_WR_DEPTH,
    parameter int STARVE_MAX = GPR_WR_STARVE_MAX
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_wbu_gpr_wr_en,
    input  logic [`GPRS_WIDTH-1:0] i_wbu_gpr_wr_id,
    input  logic [`DATA_WIDTH-1:0] i_wbu_gpr_wr_data,
    output logic                   o_arb_wbu_ready,
    gpr_wr_arb_if.slave            mdu,
    input  logic [`GPRS_WIDTH-1:0] i_idu_rs1_id,
    input  logic [`GPRS_WIDTH-1:0] i_idu_rs2_id,
    output logic                   o_arb_rs1_pend,
    output logic                   o_arb_rs2_pend,
    output logic                   o_gpr_wr_en,
    output logic [`GPRS_WIDTH-1:0] o_gpr_wr_id,
    output logic [`DATA_WIDTH-1:0] o_gpr_wr_data
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        STARVE_MAX < 1) begin : g_cfg_chk
        $error("gpr_wr_arb: bad DEPTH or STARVE_MAX");
    end

    gpr_wr_ent_t                       w_head;
    gpr_wr_ent_t                       w_push_ent;
    logic                              w_full;
    logic                              w_empty;
    logic                              w_push;
    logic                              w_pop;
    logic                              w_force;
    logic                              w_wbu_act;
    logic                              w_rs1_hit;
    logic                              w_rs2_hit;
    logic [DEPTH-1:0]                  w_vld;
    logic [DEPTH-1:0][`GPRS_WIDTH-1:0] w_ids;

    assign mdu.o_arb_mdu_ready = !w_full;
    // id-0 results complete the handshake but are dropped.
    assign w_push = mdu.i_mdu_valid && !w_full &&
                    (mdu.i_mdu_gpr_wr_id != '0);
    assign w_push_ent.id   = mdu.i_mdu_gpr_wr_id;
    assign w_push_ent.data = mdu.i_mdu_gpr_wr_data;

    // A write to x0 is treated as an idle port cycle.
    assign w_wbu_act = i_wbu_gpr_wr_en &&
                       (i_wbu_gpr_wr_id != '0);

    gpr_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (w_push),
        .i_push_ent (w_push_ent),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_vld      (w_vld),
        .o_ids      (w_ids)
    );

`ifdef GPR_WR_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    logic [CW-1:0] r_starve;

    assign w_force = !w_empty && (r_starve == SMAX);
    assign o_arb_wbu_ready = !w_force;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve <= '0;
        end else if (w_empty || w_pop) begin
            r_starve <= '0;
        end else if (r_starve != SMAX) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    assign w_force = 1'b0;
    assign o_arb_wbu_ready = 1'b1;
`endif

    always_comb begin
        o_gpr_wr_en   = 1'b0;
        o_gpr_wr_id   = '0;
        o_gpr_wr_data = `DATA_ZERO;
        w_pop         = 1'b0;
        if (w_force) begin
            o_gpr_wr_en   = 1'b1;
            o_gpr_wr_id   = w_head.id;
            o_gpr_wr_data = w_head.data;
            w_pop         = 1'b1;
        end else if (w_wbu_act) begin
            o_gpr_wr_en   = 1'b1;
            o_gpr_wr_id   = i_wbu_gpr_wr_id;
            o_gpr_wr_data = i_wbu_gpr_wr_data;
        end else if (!w_empty) begin
            o_gpr_wr_en   = 1'b1;
            o_gpr_wr_id   = w_head.id;
            o_gpr_wr_data = w_head.data;
            w_pop         = 1'b1;
        end
    end

    // The entry popped this cycle is still occupied, so it still
    // flags a hazard until the regfile holds the value.
    always_comb begin
        w_rs1_hit = 1'b0;
        w_rs2_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_vld[i] && w_ids[i] == i_idu_rs1_id)
                w_rs1_hit = 1'b1;
            if (w_vld[i] && w_ids[i] == i_idu_rs2_id)
                w_rs2_hit = 1'b1;
        end
    end

    assign o_arb_rs1_pend = w_rs1_hit && (i_idu_rs1_id != '0);
    assign o_arb_rs2_pend = w_rs2_hit && (i_idu_rs2_id != '0);

endmodule

// File: tb/tb_gpr_wr_arb.sv
// Directed self-checking bench for gpr_wr_arb.
// Covers reset, queueing, full/wrap, starve guard, id 0, reset flush.
module tb_gpr_wr_arb;

    logic        clk;
    logic        rst_n;
    logic        wbu_en;
    logic [4:0]  wbu_id;
    logic [31:0] wbu_data;
    logic        wbu_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        pend1;
    logic        pend2;
    logic        wr_en;
    logic [4:0]  wr_id;
    logic [31:0] wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    gpr_wr_arb_if mif ();

    gpr_wr_arb #(
        .DEPTH      (4),
        .STARVE_MAX (8)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_wbu_gpr_wr_en   (wbu_en),
        .i_wbu_gpr_wr_id   (wbu_id),
        .i_wbu_gpr_wr_data (wbu_data),
        .o_arb_wbu_ready   (wbu_ready),
        .mdu               (mif),
        .i_idu_rs1_id      (rs1),
        .i_idu_rs2_id      (rs2),
        .o_arb_rs1_pend    (pend1),
        .o_arb_rs2_pend    (pend2),
        .o_gpr_wr_en       (wr_en),
        .o_gpr_wr_id       (wr_id),
        .o_gpr_wr_data     (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wbu_en   = 1'b0;
        wbu_id   = '0;
        wbu_data = '0;
        mif.i_mdu_valid       = 1'b0;
        mif.i_mdu_gpr_wr_id   = '0;
        mif.i_mdu_gpr_wr_data = '0;
    endtask

    task automatic wbu(input logic [4:0] id, input logic [31:0] d);
        wbu_en   = 1'b1;
        wbu_id   = id;
        wbu_data = d;
    endtask

    task automatic mpush(input logic [4:0] id, input logic [31:0] d);
        mif.i_mdu_valid       = 1'b1;
        mif.i_mdu_gpr_wr_id   = id;
        mif.i_mdu_gpr_wr_data = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        rs1 = 5'd5;
        rs2 = 5'd7;
        #3;
        n_tests++;
        if ({wr_en, wr_id, wr_data} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_wr got=%0b/%0d/%h exp=0/0/0",
                     wr_en, wr_id, wr_data);
        end
        n_tests++;
        if ({mif.o_arb_mdu_ready, wbu_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_ready got=%0b%0b exp=11",
                     mif.o_arb_mdu_ready, wbu_ready);
        end
        n_tests++;
        if ({pend1, pend2} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_pend got=%0b%0b exp=00", pend1, pend2);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mdu_single();
        mpush(5'd5, 32'h1234);
        #1;
        n_tests++;
        if (wr_en !== 1'b0 || mif.o_arb_mdu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_nobypass got=en%0b rdy%0b exp=en0 rdy1",
                     wr_en, mif.o_arb_mdu_ready);
        end
        step();
        idle();
        #1;
        n_tests++;
        if (wr_en !== 1'b1 || wr_id !== 5'd5 || wr_data !== 32'h1234) begin
            n_fail++;
            $display("FAIL single_write got=%0b/%0d/%h exp=1/5/1234",
                     wr_en, wr_id, wr_data);
        end
        step();
        n_tests++;
        if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL single_empty got=%0b exp=0", wr_en);
        end
    endtask

    task automatic test_pipe_priority();
        rs1 = 5'd7;
        wbu(5'd3, 32'hAAAA);
        mpush(5'd7, 32'hBEEF);
        #1;
        n_tests++;
        if (wr_id !== 5'd3 || pend1 !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_c0 got=id%0d pend%0b exp=id3 pend0",
                     wr_id, pend1);
        end
        step();
        mif.i_mdu_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (wr_en !== 1'b1 || wr_id !== 5'd3 || pend1 !== 1'b1) begin
                n_fail++;
                $display("FAIL prio_busy%0d got=%0b/%0d p%0b exp=1/3 p1",
                         k, wr_en, wr_id, pend1);
            end
            step();
        end
        idle();
        #1;
        n_tests++;
        if (wr_id !== 5'd7 || wr_data !== 32'hBEEF || pend1 !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_drain got=%0d/%h p%0b exp=7/beef p1",
                     wr_id, wr_data, pend1);
        end
        step();
        n_tests++;
        if (wr_en !== 1'b0 || pend1 !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_after got=en%0b p%0b exp=en0 p0",
                     wr_en, pend1);
        end
    endtask

    task automatic test_full_wrap();
        logic [4:0] ids [5];
        ids[0] = 5'd1;
        ids[1] = 5'd2;
        ids[2] = 5'd4;
        ids[3] = 5'd6;
        ids[4] = 5'd9;
        wbu(5'd3, 32'h3333);
        for (int i = 0; i < 4; i++) begin
            mpush(ids[i], 32'h100 + i);
            #1;
            n_tests++;
            if (mif.o_arb_mdu_ready !== 1'b1 || wr_id !== 5'd3) begin
                n_fail++;
                $display("FAIL full_push%0d got=rdy%0b id%0d exp=rdy1 id3",
                         i, mif.o_arb_mdu_ready, wr_id);
            end
            step();
        end
        mpush(ids[4], 32'h900);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_tests++;
            if (mif.o_arb_mdu_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL full_hold%0d got=%0b exp=0",
                         k, mif.o_arb_mdu_ready);
            end
            step();
        end
        wbu_en = 1'b0;
        #1;
        n_tests++;
        if (mif.o_arb_mdu_ready !== 1'b0 || wr_id !== 5'd1 ||
            wr_data !== 32'h100) begin
            n_fail++;
            $display("FAIL full_pop got=rdy%0b %0d/%h exp=rdy0 1/100",
                     mif.o_arb_mdu_ready, wr_id, wr_data);
        end
        step();
        #1;
        n_tests++;
        if (mif.o_arb_mdu_ready !== 1'b1 || wr_id !== 5'd2) begin
            n_fail++;
            $display("FAIL full_reopen got=rdy%0b id%0d exp=rdy1 id2",
                     mif.o_arb_mdu_ready, wr_id);
        end
        step();
        mif.i_mdu_valid = 1'b0;
        for (int i = 2; i < 5; i++) begin
            #1;
            n_tests++;
            if (wr_en !== 1'b1 || wr_id !== ids[i] ||
                wr_data !== (i == 4 ? 32'h900 : 32'h100 + i)) begin
                n_fail++;
                $display("FAIL wrap_order%0d got=%0b/%0d/%h exp id=%0d",
                         i, wr_en, wr_id, wr_data, ids[i]);
            end
            step();
        end
        n_tests++;
        if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_empty got=%0b exp=0", wr_en);
        end
    endtask

    task automatic test_starve();
        rs1 = 5'd12;
        wbu(5'd3, 32'h3333);
        mpush(5'd12, 32'hC0DE);
        step();
        mif.i_mdu_valid = 1'b0;
`ifdef GPR_WR_ARB_STARVE_EN
        for (int k = 1; k <= 8; k++) begin
            #1;
            n_tests++;
            if (wr_id !== 5'd3 || wbu_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL starve_wait%0d got=id%0d r%0b exp=id3 r1",
                         k, wr_id, wbu_ready);
            end
            step();
        end
        #1;
        n_tests++;
        if (wr_id !== 5'd12 || wr_data !== 32'hC0DE ||
            wbu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_force got=%0d/%h r%0b exp=12/c0de r0",
                     wr_id, wr_data, wbu_ready);
        end
        step();
        #1;
        n_tests++;
        if (wr_id !== 5'd3 || wbu_ready !== 1'b1 || pend1 !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_after got=id%0d r%0b p%0b exp=3 1 0",
                     wr_id, wbu_ready, pend1);
        end
        idle();
        step();
`else
        for (int k = 1; k <= 20; k++) begin
            #1;
            n_tests++;
            if (wr_id !== 5'd3 || wbu_ready !== 1'b1 || pend1 !== 1'b1) begin
                n_fail++;
                $display("FAIL nostarve%0d got=id%0d r%0b p%0b exp=3 1 1",
                         k, wr_id, wbu_ready, pend1);
            end
            step();
        end
        idle();
        #1;
        n_tests++;
        if (wr_id !== 5'd12 || wr_data !== 32'hC0DE) begin
            n_fail++;
            $display("FAIL nostarve_drain got=%0d/%h exp=12/c0de",
                     wr_id, wr_data);
        end
        step();
`endif
    endtask

    task automatic test_id0();
        wbu(5'd0, 32'hDEAD);
        mpush(5'd0, 32'h5555);
        #1;
        n_tests++;
        if (mif.o_arb_mdu_ready !== 1'b1 || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL id0_hs got=rdy%0b en%0b exp=rdy1 en0",
                     mif.o_arb_mdu_ready, wr_en);
        end
        step();
        mif.i_mdu_valid = 1'b0;
        #1;
        n_tests++;
        if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL id0_nostore got=%0b/%0d exp=0", wr_en, wr_id);
        end
        wbu(5'd3, 32'h3333);
        mpush(5'd8, 32'h8888);
        step();
        mif.i_mdu_valid = 1'b0;
        wbu(5'd0, 32'hDEAD);
        #1;
        n_tests++;
        if (wr_en !== 1'b1 || wr_id !== 5'd8 || wr_data !== 32'h8888) begin
            n_fail++;
            $display("FAIL id0_drain got=%0b/%0d/%h exp=1/8/8888",
                     wr_en, wr_id, wr_data);
        end
        step();
        idle();
    endtask

    task automatic test_reset_mid();
        rs1 = 5'd5;
        rs2 = 5'd7;
        wbu(5'd3, 32'h3333);
        mpush(5'd5, 32'h55);
        step();
        mpush(5'd6, 32'h66);
        step();
        mpush(5'd7, 32'h77);
        step();
        mif.i_mdu_valid = 1'b0;
        #1;
        n_tests++;
        if ({pend1, pend2} !== 2'b11) begin
            n_fail++;
            $display("FAIL rmid_pend got=%0b%0b exp=11", pend1, pend2);
        end
        rst_n = 1'b0;
        idle();
        step();
        n_tests++;
        if ({pend1, pend2, mif.o_arb_mdu_ready, wr_en} !== 4'b0010) begin
            n_fail++;
            $display("FAIL rmid_flush got=p%0b%0b rdy%0b en%0b exp=00 1 0",
                     pend1, pend2, mif.o_arb_mdu_ready, wr_en);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_tests++;
            if (wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_nowr%0d got=%0b/%0d exp=0",
                         k, wr_en, wr_id);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mdu_single();
        test_pipe_priority();
        test_full_wrap();
        test_starve();
        test_id0();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
